// File: rtl/nasti_demux_pkg.sv
// Shared NASTI definitions: response codes, port-index encoding and error-slave states.
package nasti_demux_pkg;

    localparam int unsigned NASTI_PORTS = 8;
    localparam int unsigned N_SLV       = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef logic [2:0] port_idx_t;
    localparam port_idx_t PORT_ES = 3'd7;

    typedef enum logic [1:0] {
        ES_IDLE,
        ES_WDRAIN,
        ES_WRESP,
        ES_RDATA
    } es_state_t;

endpackage

// File: rtl/nasti_channel.sv
// Bundle of NASTI channels, one lane per port index.
interface nasti_channel #(
    parameter int N_PORT     = 8,
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1
);
    localparam int STRB_W = (DATA_WIDTH + 7) / 8;

    logic [N_PORT-1:0][ID_WIDTH-1:0]   aw_id;
    logic [N_PORT-1:0][ADDR_WIDTH-1:0] aw_addr;
    logic [N_PORT-1:0][7:0]            aw_len;
    logic [N_PORT-1:0][2:0]            aw_size;
    logic [N_PORT-1:0][1:0]            aw_burst;
    logic [N_PORT-1:0][USER_WIDTH-1:0] aw_user;
    logic [N_PORT-1:0]                 aw_valid;
    logic [N_PORT-1:0]                 aw_ready;

    logic [N_PORT-1:0][DATA_WIDTH-1:0] w_data;
    logic [N_PORT-1:0][STRB_W-1:0]     w_strb;
    logic [N_PORT-1:0]                 w_last;
    logic [N_PORT-1:0][USER_WIDTH-1:0] w_user;
    logic [N_PORT-1:0]                 w_valid;
    logic [N_PORT-1:0]                 w_ready;

    logic [N_PORT-1:0][ID_WIDTH-1:0]   b_id;
    logic [N_PORT-1:0][1:0]            b_resp;
    logic [N_PORT-1:0][USER_WIDTH-1:0] b_user;
    logic [N_PORT-1:0]                 b_valid;
    logic [N_PORT-1:0]                 b_ready;

    logic [N_PORT-1:0][ID_WIDTH-1:0]   ar_id;
    logic [N_PORT-1:0][ADDR_WIDTH-1:0] ar_addr;
    logic [N_PORT-1:0][7:0]            ar_len;
    logic [N_PORT-1:0][2:0]            ar_size;
    logic [N_PORT-1:0][1:0]            ar_burst;
    logic [N_PORT-1:0][USER_WIDTH-1:0] ar_user;
    logic [N_PORT-1:0]                 ar_valid;
    logic [N_PORT-1:0]                 ar_ready;

    logic [N_PORT-1:0][ID_WIDTH-1:0]   r_id;
    logic [N_PORT-1:0][DATA_WIDTH-1:0] r_data;
    logic [N_PORT-1:0][1:0]            r_resp;
    logic [N_PORT-1:0]                 r_last;
    logic [N_PORT-1:0][USER_WIDTH-1:0] r_user;
    logic [N_PORT-1:0]                 r_valid;
    logic [N_PORT-1:0]                 r_ready;

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid, input aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid, input w_ready,
        input  b_id, b_resp, b_user, b_valid, output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user, ar_valid, input ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid, output r_ready
    );

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid, output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid, output w_ready,
        output b_id, b_resp, b_user, b_valid, input b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user, ar_valid, output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid, input r_ready
    );

endinterface

// File: rtl/nasti_err_slave.sv
// Default target for unmapped addresses: drains writes and answers every burst with DECERR.
module nasti_err_slave
    import nasti_demux_pkg::*;
#(
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LITE_MODE  = 0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_aw_valid,
    output logic                  o_aw_ready,
    input  logic [ID_WIDTH-1:0]   i_aw_id,
    input  logic                  i_w_valid,
    output logic                  o_w_ready,
    input  logic                  i_w_last,
    output logic                  o_b_valid,
    input  logic                  i_b_ready,
    output logic [ID_WIDTH-1:0]   o_b_id,
    output logic [1:0]            o_b_resp,
    input  logic                  i_ar_valid,
    output logic                  o_ar_ready,
    input  logic [ID_WIDTH-1:0]   i_ar_id,
    input  logic [7:0]            i_ar_len,
    output logic                  o_r_valid,
    input  logic                  i_r_ready,
    output logic [ID_WIDTH-1:0]   o_r_id,
    output logic [DATA_WIDTH-1:0] o_r_data,
    output logic [1:0]            o_r_resp,
    output logic                  o_r_last
);

    // Write and read sides each run their own copy of the state machine.
    es_state_t r_wst, w_wst_nxt;
    es_state_t r_rst, w_rst_nxt;
    logic [ID_WIDTH-1:0] r_bid, r_rid;
    logic [7:0]          r_rlen, r_rbeat;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wst   <= ES_IDLE;
            r_rst   <= ES_IDLE;
            r_bid   <= '0;
            r_rid   <= '0;
            r_rlen  <= '0;
            r_rbeat <= '0;
        end else begin
            r_wst <= w_wst_nxt;
            r_rst <= w_rst_nxt;
            if (i_aw_valid && o_aw_ready)
                r_bid <= i_aw_id;
            if (i_ar_valid && o_ar_ready) begin
                r_rid   <= i_ar_id;
                r_rlen  <= i_ar_len;
                r_rbeat <= '0;
            end else if (o_r_valid && i_r_ready) begin
                r_rbeat <= r_rbeat + 8'd1;
            end
        end
    end

    always_comb begin
        w_wst_nxt  = r_wst;
        o_aw_ready = 1'b0;
        o_w_ready  = 1'b0;
        o_b_valid  = 1'b0;
        case (r_wst)
            ES_IDLE: begin
                o_aw_ready = 1'b1;
                if (i_aw_valid) w_wst_nxt = ES_WDRAIN;
            end
            ES_WDRAIN: begin
                o_w_ready = 1'b1;
                if (i_w_valid && (LITE_MODE != 0 || i_w_last)) w_wst_nxt = ES_WRESP;
            end
            ES_WRESP: begin
                o_b_valid = 1'b1;
                if (i_b_ready) w_wst_nxt = ES_IDLE;
            end
            default: w_wst_nxt = ES_IDLE;
        endcase
    end

    always_comb begin
        w_rst_nxt  = r_rst;
        o_ar_ready = 1'b0;
        o_r_valid  = 1'b0;
        o_r_last   = 1'b0;
        case (r_rst)
            ES_IDLE: begin
                o_ar_ready = 1'b1;
                if (i_ar_valid) w_rst_nxt = ES_RDATA;
            end
            ES_RDATA: begin
                o_r_valid = 1'b1;
                o_r_last  = (r_rbeat == r_rlen);
                if (i_r_ready && o_r_last) w_rst_nxt = ES_IDLE;
            end
            default: w_rst_nxt = ES_IDLE;
        endcase
    end

    assign o_b_id   = r_bid;
    assign o_b_resp = RESP_DECERR;
    assign o_r_id   = r_rid;
    assign o_r_data = '0;
    assign o_r_resp = RESP_DECERR;

endmodule

// File: rtl/nasti_demux.sv
// One-to-four NASTI address demultiplexer; unmapped addresses go to an internal error slave.
module nasti_demux
    import nasti_demux_pkg::*;
#(
    parameter int unsigned           ID_WIDTH   = 1,
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           USER_WIDTH = 1,
    parameter int unsigned           LITE_MODE  = 0,
    parameter int unsigned           OUT_MAX    = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE0 = '0,
    parameter logic [ADDR_WIDTH-1:0] BASE1 = '0,
    parameter logic [ADDR_WIDTH-1:0] BASE2 = '0,
    parameter logic [ADDR_WIDTH-1:0] BASE3 = '0,
    parameter logic [ADDR_WIDTH-1:0] MASK0 = '0,
    parameter logic [ADDR_WIDTH-1:0] MASK1 = '0,
    parameter logic [ADDR_WIDTH-1:0] MASK2 = '0,
    parameter logic [ADDR_WIDTH-1:0] MASK3 = '0
) (
    input logic          clk,
    input logic          rstn,
    nasti_channel.slave  master,
    nasti_channel.master slave
);

    localparam int unsigned CW = $clog2(OUT_MAX + 1);
    localparam logic [CW-1:0] C_MAX = CW'(OUT_MAX);
    localparam logic [N_SLV-1:0][ADDR_WIDTH-1:0] BASES = {BASE3, BASE2, BASE1, BASE0};
    localparam logic [N_SLV-1:0][ADDR_WIDTH-1:0] MASKS = {MASK3, MASK2, MASK1, MASK0};

    function automatic port_idx_t f_decode(input logic [ADDR_WIDTH-1:0] addr);
        port_idx_t sel = PORT_ES;
        // Scan downwards so the lowest matching window wins.
        for (int unsigned i = N_SLV; i > 0; i--)
            if ((addr & MASKS[i-1]) == BASES[i-1]) sel = port_idx_t'(i-1);
        return sel;
    endfunction

    logic [CW-1:0] r_wcnt, r_rcnt;
    port_idx_t     r_wown, r_rown, r_wport;
    logic          r_wlock;

    port_idx_t w_aw_port, w_ar_port;
    logic      w_aw_go, w_ar_go, w_b_en, w_r_en;
    logic      w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_end;

    logic                  w_es_aw_valid, w_es_aw_ready, w_es_w_valid, w_es_w_ready;
    logic                  w_es_b_valid, w_es_b_ready, w_es_ar_valid, w_es_ar_ready;
    logic                  w_es_r_valid, w_es_r_ready, w_es_r_last;
    logic [ID_WIDTH-1:0]   w_es_b_id, w_es_r_id;
    logic [1:0]            w_es_b_resp, w_es_r_resp;
    logic [DATA_WIDTH-1:0] w_es_r_data;

    assign w_aw_port = f_decode(master.aw_addr[0]);
    assign w_ar_port = f_decode(master.ar_addr[0]);

    // A new burst may only join the current owner so responses stay in order.
    assign w_aw_go = rstn && !r_wlock && (r_wcnt != C_MAX)
                   && !((r_wcnt != '0) && (w_aw_port != r_wown));
    assign w_ar_go = rstn && (r_rcnt != C_MAX)
                   && !((r_rcnt != '0) && (w_ar_port != r_rown));
    assign w_b_en  = (r_wcnt != '0);
    assign w_r_en  = (r_rcnt != '0);

    assign w_aw_hs = master.aw_valid[0] && master.aw_ready[0];
    assign w_w_hs  = master.w_valid[0] && master.w_ready[0];
    assign w_b_hs  = master.b_valid[0] && master.b_ready[0];
    assign w_ar_hs = master.ar_valid[0] && master.ar_ready[0];
    assign w_r_end = master.r_valid[0] && master.r_ready[0] && master.r_last[0];

    always_comb begin
        slave.aw_id = '0; slave.aw_addr = '0; slave.aw_len = '0; slave.aw_size = '0;
        slave.aw_burst = '0; slave.aw_user = '0; slave.aw_valid = '0;
        slave.ar_id = '0; slave.ar_addr = '0; slave.ar_len = '0; slave.ar_size = '0;
        slave.ar_burst = '0; slave.ar_user = '0; slave.ar_valid = '0;
        slave.w_data = '0; slave.w_strb = '0; slave.w_last = '0; slave.w_user = '0;
        slave.w_valid = '0; slave.b_ready = '0; slave.r_ready = '0;
        for (int unsigned i = 0; i < N_SLV; i++) begin
            slave.aw_id[i]    = master.aw_id[0];
            slave.aw_addr[i]  = master.aw_addr[0];
            slave.aw_len[i]   = master.aw_len[0];
            slave.aw_size[i]  = master.aw_size[0];
            slave.aw_burst[i] = master.aw_burst[0];
            slave.aw_user[i]  = master.aw_user[0];
            slave.aw_valid[i] = master.aw_valid[0] && w_aw_go && (w_aw_port == port_idx_t'(i));
            slave.ar_id[i]    = master.ar_id[0];
            slave.ar_addr[i]  = master.ar_addr[0];
            slave.ar_len[i]   = master.ar_len[0];
            slave.ar_size[i]  = master.ar_size[0];
            slave.ar_burst[i] = master.ar_burst[0];
            slave.ar_user[i]  = master.ar_user[0];
            slave.ar_valid[i] = master.ar_valid[0] && w_ar_go && (w_ar_port == port_idx_t'(i));
            slave.w_data[i]   = master.w_data[0];
            slave.w_strb[i]   = master.w_strb[0];
            slave.w_last[i]   = master.w_last[0];
            slave.w_user[i]   = master.w_user[0];
            slave.w_valid[i]  = master.w_valid[0] && r_wlock && (r_wport == port_idx_t'(i));
            slave.b_ready[i]  = master.b_ready[0] && w_b_en && (r_wown == port_idx_t'(i));
            slave.r_ready[i]  = master.r_ready[0] && w_r_en && (r_rown == port_idx_t'(i));
        end
        w_es_aw_valid = master.aw_valid[0] && w_aw_go && (w_aw_port == PORT_ES);
        w_es_ar_valid = master.ar_valid[0] && w_ar_go && (w_ar_port == PORT_ES);
        w_es_w_valid  = master.w_valid[0] && r_wlock && (r_wport == PORT_ES);
        w_es_b_ready  = master.b_ready[0] && w_b_en && (r_wown == PORT_ES);
        w_es_r_ready  = master.r_ready[0] && w_r_en && (r_rown == PORT_ES);
    end

    always_comb begin
        master.aw_ready = '0; master.w_ready = '0; master.ar_ready = '0;
        master.b_id = '0; master.b_resp = '0; master.b_user = '0; master.b_valid = '0;
        master.r_id = '0; master.r_data = '0; master.r_resp = '0; master.r_last = '0;
        master.r_user = '0; master.r_valid = '0;
        master.aw_ready[0] = w_aw_go && ((w_aw_port == PORT_ES) ? w_es_aw_ready : slave.aw_ready[w_aw_port]);
        master.ar_ready[0] = w_ar_go && ((w_ar_port == PORT_ES) ? w_es_ar_ready : slave.ar_ready[w_ar_port]);
        master.w_ready[0]  = r_wlock && ((r_wport == PORT_ES) ? w_es_w_ready : slave.w_ready[r_wport]);
        if (r_wown == PORT_ES) begin
            master.b_valid[0] = w_b_en && w_es_b_valid;
            master.b_id[0]    = w_es_b_id;
            master.b_resp[0]  = w_es_b_resp;
        end else begin
            master.b_valid[0] = w_b_en && slave.b_valid[r_wown];
            master.b_id[0]    = slave.b_id[r_wown];
            master.b_resp[0]  = slave.b_resp[r_wown];
            master.b_user[0]  = slave.b_user[r_wown];
        end
        if (r_rown == PORT_ES) begin
            master.r_valid[0] = w_r_en && w_es_r_valid;
            master.r_id[0]    = w_es_r_id;
            master.r_data[0]  = w_es_r_data;
            master.r_resp[0]  = w_es_r_resp;
            master.r_last[0]  = w_es_r_last;
        end else begin
            master.r_valid[0] = w_r_en && slave.r_valid[r_rown];
            master.r_id[0]    = slave.r_id[r_rown];
            master.r_data[0]  = slave.r_data[r_rown];
            master.r_resp[0]  = slave.r_resp[r_rown];
            master.r_last[0]  = slave.r_last[r_rown];
            master.r_user[0]  = slave.r_user[r_rown];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wcnt  <= '0;
            r_rcnt  <= '0;
            r_wown  <= '0;
            r_rown  <= '0;
            r_wport <= '0;
            r_wlock <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_wlock <= 1'b1;
                r_wport <= w_aw_port;
                r_wown  <= w_aw_port;
            end else if (w_w_hs && (LITE_MODE != 0 || master.w_last[0])) begin
                r_wlock <= 1'b0;
            end
            if (w_ar_hs)
                r_rown <= w_ar_port;
            case ({w_aw_hs, w_b_hs})
                2'b10:   r_wcnt <= r_wcnt + CW'(1);
                2'b01:   r_wcnt <= r_wcnt - CW'(1);
                default: r_wcnt <= r_wcnt;
            endcase
            case ({w_ar_hs, w_r_end})
                2'b10:   r_rcnt <= r_rcnt + CW'(1);
                2'b01:   r_rcnt <= r_rcnt - CW'(1);
                default: r_rcnt <= r_rcnt;
            endcase
        end
    end

    nasti_err_slave #(
        .ID_WIDTH   (ID_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .LITE_MODE  (LITE_MODE)
    ) u_es (
        .clk        (clk),
        .rstn       (rstn),
        .i_aw_valid (w_es_aw_valid),
        .o_aw_ready (w_es_aw_ready),
        .i_aw_id    (master.aw_id[0]),
        .i_w_valid  (w_es_w_valid),
        .o_w_ready  (w_es_w_ready),
        .i_w_last   (master.w_last[0]),
        .o_b_valid  (w_es_b_valid),
        .i_b_ready  (w_es_b_ready),
        .o_b_id     (w_es_b_id),
        .o_b_resp   (w_es_b_resp),
        .i_ar_valid (w_es_ar_valid),
        .o_ar_ready (w_es_ar_ready),
        .i_ar_id    (master.ar_id[0]),
        .i_ar_len   (master.ar_len[0]),
        .o_r_valid  (w_es_r_valid),
        .i_r_ready  (w_es_r_ready),
        .o_r_id     (w_es_r_id),
        .o_r_data   (w_es_r_data),
        .o_r_resp   (w_es_r_resp),
        .o_r_last   (w_es_r_last)
    );

    logic w_unused;
    assign w_unused = ^{master.aw_valid[NASTI_PORTS-1:1], master.w_valid[NASTI_PORTS-1:1],
                        master.b_ready[NASTI_PORTS-1:1], master.ar_valid[NASTI_PORTS-1:1],
                        master.r_ready[NASTI_PORTS-1:1]};

endmodule

// File: tb/tb_nasti_demux.sv
// Directed bench for nasti_demux: four 16-byte windows at 0x00..0x3F, everything else unmapped.
module tb_nasti_demux;
    import nasti_demux_pkg::*;

    localparam int IW = 2;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    nasti_channel #(.N_PORT(8), .ID_WIDTH(IW), .ADDR_WIDTH(8), .DATA_WIDTH(8), .USER_WIDTH(1)) m_if ();
    nasti_channel #(.N_PORT(8), .ID_WIDTH(IW), .ADDR_WIDTH(8), .DATA_WIDTH(8), .USER_WIDTH(1)) s_if ();

    nasti_demux #(
        .ID_WIDTH (IW), .ADDR_WIDTH (8), .DATA_WIDTH (8), .USER_WIDTH (1),
        .LITE_MODE (0), .OUT_MAX (4),
        .BASE0 (8'h00), .MASK0 (8'hF0), .BASE1 (8'h10), .MASK1 (8'hF0),
        .BASE2 (8'h20), .MASK2 (8'hF0), .BASE3 (8'h30), .MASK3 (8'hF0)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .master (m_if),
        .slave  (s_if)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        m_if.aw_id = '0; m_if.aw_addr = '0; m_if.aw_len = '0; m_if.aw_size = '0;
        m_if.aw_burst = '0; m_if.aw_user = '0; m_if.aw_valid = '0;
        m_if.w_data = '0; m_if.w_strb = '0; m_if.w_last = '0; m_if.w_user = '0; m_if.w_valid = '0;
        m_if.b_ready = '0;
        m_if.ar_id = '0; m_if.ar_addr = '0; m_if.ar_len = '0; m_if.ar_size = '0;
        m_if.ar_burst = '0; m_if.ar_user = '0; m_if.ar_valid = '0;
        m_if.r_ready = '0;
        s_if.aw_ready = '0; s_if.w_ready = '0; s_if.ar_ready = '0;
        s_if.b_id = '0; s_if.b_resp = '0; s_if.b_user = '0; s_if.b_valid = '0;
        s_if.r_id = '0; s_if.r_data = '0; s_if.r_resp = '0; s_if.r_last = '0;
        s_if.r_user = '0; s_if.r_valid = '0;
    endtask

    // One single-beat write to port 3 (AW cycle, then W cycle).
    task automatic wr_p3(input string tag);
        m_if.aw_valid[0] = 1'b1; m_if.aw_addr[0] = 8'h30; m_if.aw_len[0] = 8'd0;
        #1;
        chk({tag, "_aw_ready"}, m_if.aw_ready[0], 1);
        nxt();
        m_if.aw_valid[0] = 1'b0;
        m_if.w_valid[0] = 1'b1; m_if.w_last[0] = 1'b1;
        #1;
        chk({tag, "_w_route"}, s_if.w_valid, 8'h08);
        nxt();
        m_if.w_valid[0] = 1'b0; m_if.w_last[0] = 1'b0;
    endtask

    initial begin
        clear_all();
        repeat (2) @(posedge clk);
        #1;
        // Reset: everything quiet even with live requests and ready slaves
        m_if.aw_valid[0] = 1'b1; m_if.aw_addr[0] = 8'h10;
        m_if.ar_valid[0] = 1'b1; m_if.ar_addr[0] = 8'hF0;
        m_if.w_valid[0] = 1'b1; m_if.b_ready[0] = 1'b1; m_if.r_ready[0] = 1'b1;
        s_if.aw_ready = '1; s_if.ar_ready = '1; s_if.w_ready = '1; s_if.b_valid = '1; s_if.r_valid = '1;
        #1;
        chk("rst_aw_ready", m_if.aw_ready, 0);
        chk("rst_ar_ready", m_if.ar_ready, 0);
        chk("rst_w_ready", m_if.w_ready, 0);
        chk("rst_b_valid", m_if.b_valid, 0);
        chk("rst_r_valid", m_if.r_valid, 0);
        chk("rst_s_aw_valid", s_if.aw_valid, 0);
        chk("rst_s_ar_valid", s_if.ar_valid, 0);
        chk("rst_s_b_ready", s_if.b_ready, 0);
        clear_all();
        s_if.aw_ready = '1; s_if.ar_ready = '1; s_if.w_ready = '1;
        nxt();
        rstn = 1'b1;
        nxt();

        // Write burst to port 1, len=3
        m_if.aw_valid[0] = 1'b1; m_if.aw_addr[0] = 8'h10; m_if.aw_len[0] = 8'd3; m_if.aw_id[0] = 2'd2;
        #1;
        chk("w1_s_aw_valid", s_if.aw_valid, 8'h02);
        chk("w1_aw_ready", m_if.aw_ready[0], 1);
        chk("w1_s_aw_len", s_if.aw_len[1], 3);
        nxt();
        m_if.aw_valid[0] = 1'b0;
        for (int b = 0; b < 4; b++) begin
            m_if.w_valid[0] = 1'b1; m_if.w_data[0] = 8'(8'hA0 + b); m_if.w_last[0] = (b == 3);
            if (b == 1) begin
                m_if.aw_valid[0] = 1'b1; m_if.aw_addr[0] = 8'h10;
            end
            #1;
            chk("w1_s_w_valid", s_if.w_valid, 8'h02);
            chk("w1_w_ready", m_if.w_ready[0], 1);
            chk("w1_s_w_data", s_if.w_data[1], 32'(8'hA0 + b));
            if (b == 1) begin
                chk("w1_aw_locked", m_if.aw_ready[0], 0);
                chk("w1_aw_locked_s", s_if.aw_valid, 0);
            end
            nxt();
            m_if.aw_valid[0] = 1'b0;
        end
        m_if.w_valid[0] = 1'b0; m_if.w_last[0] = 1'b0;
        #1;
        chk("w1_w_idle", s_if.w_valid, 0);
        s_if.b_valid[1] = 1'b1; s_if.b_id[1] = 2'd2; s_if.b_resp[1] = RESP_OKAY; m_if.b_ready[0] = 1'b1;
        #1;
        chk("w1_b_valid", m_if.b_valid[0], 1);
        chk("w1_b_id", m_if.b_id[0], 2);
        chk("w1_b_resp", m_if.b_resp[0], 0);
        chk("w1_s_b_ready", s_if.b_ready, 8'h02);
        nxt();
        s_if.b_valid[1] = 1'b0; m_if.b_ready[0] = 1'b0;
        m_if.aw_valid[0] = 1'b1; m_if.aw_addr[0] = 8'h20;
        #1;
        chk("w1_cnt0_aw_ready", m_if.aw_ready[0], 1);
        chk("w1_cnt0_s_aw_valid", s_if.aw_valid, 8'h04);
        m_if.aw_valid[0] = 1'b0;
        nxt();

        // Write to unmapped address, len=1: drained and answered with DECERR
        m_if.aw_valid[0] = 1'b1; m_if.aw_addr[0] = 8'hF0; m_if.aw_len[0] = 8'd1; m_if.aw_id[0] = 2'd3;
        #1;
        chk("esw_aw_ready", m_if.aw_ready[0], 1);
        chk("esw_s_aw_valid", s_if.aw_valid, 0);
        nxt();
        m_if.aw_valid[0] = 1'b0;
        for (int b = 0; b < 2; b++) begin
            m_if.w_valid[0] = 1'b1; m_if.w_last[0] = (b == 1);
            #1;
            chk("esw_w_ready", m_if.w_ready[0], 1);
            chk("esw_s_w_valid", s_if.w_valid, 0);
            chk("esw_no_early_b", m_if.b_valid[0], 0);
            nxt();
        end
        m_if.w_valid[0] = 1'b0; m_if.w_last[0] = 1'b0;
        #1;
        chk("esw_b_valid", m_if.b_valid[0], 1);
        chk("esw_b_resp", m_if.b_resp[0], 3);
        chk("esw_b_id", m_if.b_id[0], 3);
        nxt();
        chk("esw_b_hold", m_if.b_valid[0], 1);
        m_if.b_ready[0] = 1'b1;
        nxt();
        chk("esw_b_done", m_if.b_valid[0], 0);
        m_if.b_ready[0] = 1'b0;

        // Read to unmapped 0xF0, len=2, id=1
        m_if.ar_valid[0] = 1'b1; m_if.ar_addr[0] = 8'hF0; m_if.ar_len[0] = 8'd2; m_if.ar_id[0] = 2'd1;
        #1;
        chk("esr_ar_ready", m_if.ar_ready[0], 1);
        chk("esr_s_ar_valid", s_if.ar_valid, 0);
        nxt();
        m_if.ar_valid[0] = 1'b0;
        #1;
        chk("esr_hold_valid", m_if.r_valid[0], 1);
        chk("esr_hold_last", m_if.r_last[0], 0);
        nxt();
        m_if.r_ready[0] = 1'b1;
        for (int b = 0; b < 3; b++) begin
            #1;
            chk("esr_r_valid", m_if.r_valid[0], 1);
            chk("esr_r_data", m_if.r_data[0], 0);
            chk("esr_r_resp", m_if.r_resp[0], 3);
            chk("esr_r_id", m_if.r_id[0], 1);
            chk("esr_r_last", m_if.r_last[0], (b == 2) ? 1 : 0);
            nxt();
        end
        #1;
        chk("esr_done", m_if.r_valid[0], 0);
        m_if.r_ready[0] = 1'b0;

        // Read ordering: port 0 outstanding blocks a read to port 2
        m_if.ar_valid[0] = 1'b1; m_if.ar_addr[0] = 8'h00; m_if.ar_len[0] = 8'd0; m_if.ar_id[0] = 2'd0;
        #1;
        chk("ord_s_ar_valid0", s_if.ar_valid, 8'h01);
        chk("ord_ar_ready0", m_if.ar_ready[0], 1);
        nxt();
        m_if.ar_addr[0] = 8'h20; m_if.ar_id[0] = 2'd1;
        #1;
        chk("ord_ar_blocked", m_if.ar_ready[0], 0);
        chk("ord_s_ar_blocked", s_if.ar_valid, 0);
        nxt();
        s_if.r_valid[0] = 1'b1; s_if.r_last[0] = 1'b1; s_if.r_data[0] = 8'h55; m_if.r_ready[0] = 1'b1;
        #1;
        chk("ord_r0_valid", m_if.r_valid[0], 1);
        chk("ord_r0_data", m_if.r_data[0], 8'h55);
        chk("ord_s_r_ready", s_if.r_ready, 8'h01);
        chk("ord_ar_still_blocked", m_if.ar_ready[0], 0);
        nxt();
        s_if.r_valid[0] = 1'b0; s_if.r_last[0] = 1'b0;
        #1;
        chk("ord_ar_released", m_if.ar_ready[0], 1);
        chk("ord_s_ar_valid2", s_if.ar_valid, 8'h04);
        nxt();
        m_if.ar_valid[0] = 1'b0;
        s_if.r_valid[2] = 1'b1; s_if.r_last[2] = 1'b1; s_if.r_data[2] = 8'h66; s_if.r_id[2] = 2'd1;
        #1;
        chk("ord_r2_data", m_if.r_data[0], 8'h66);
        chk("ord_r2_id", m_if.r_id[0], 1);
        chk("ord_s_r_ready2", s_if.r_ready, 8'h04);
        nxt();
        s_if.r_valid[2] = 1'b0; s_if.r_last[2] = 1'b0; m_if.r_ready[0] = 1'b0;

        // OUT_MAX writes to port 3 with B held back
        wr_p3("om1"); wr_p3("om2"); wr_p3("om3"); wr_p3("om4");
        m_if.aw_valid[0] = 1'b1; m_if.aw_addr[0] = 8'h30;
        #1;
        chk("om_5th_stalled", m_if.aw_ready[0], 0);
        chk("om_5th_s_aw", s_if.aw_valid, 0);
        nxt();
        s_if.b_valid[3] = 1'b1; m_if.b_ready[0] = 1'b1;
        #1;
        chk("om_b_at_max", m_if.b_valid[0], 1);
        chk("om_aw_still_full", m_if.aw_ready[0], 0);
        nxt();
        s_if.b_valid[3] = 1'b0;
        #1;
        chk("om_5th_released", m_if.aw_ready[0], 1);
        nxt();
        m_if.aw_valid[0] = 1'b0;
        m_if.w_valid[0] = 1'b1; m_if.w_last[0] = 1'b1;
        nxt();
        m_if.w_valid[0] = 1'b0; m_if.w_last[0] = 1'b0;
        s_if.b_valid[3] = 1'b1;
        nxt();
        // B handshake and AW handshake together: count stays at 3
        m_if.aw_valid[0] = 1'b1;
        #1;
        chk("sim_aw_ready", m_if.aw_ready[0], 1);
        chk("sim_b_valid", m_if.b_valid[0], 1);
        nxt();
        m_if.aw_valid[0] = 1'b0; s_if.b_valid[3] = 1'b0;
        m_if.w_valid[0] = 1'b1; m_if.w_last[0] = 1'b1;
        #1;
        chk("sim_w_route", s_if.w_valid, 8'h08);
        nxt();
        m_if.w_valid[0] = 1'b0; m_if.w_last[0] = 1'b0;
        s_if.b_valid[3] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("drain_b_valid", m_if.b_valid[0], 1);
            nxt();
        end
        #1;
        chk("drain_no_extra_b", m_if.b_valid[0], 0);
        chk("drain_s_b_ready", s_if.b_ready, 0);
        s_if.b_valid[3] = 1'b0; m_if.b_ready[0] = 1'b0;
        m_if.aw_valid[0] = 1'b1; m_if.aw_addr[0] = 8'h00;
        #1;
        chk("drain_owner_free", m_if.aw_ready[0], 1);
        chk("drain_s_aw_valid0", s_if.aw_valid, 8'h01);
        m_if.aw_valid[0] = 1'b0;
        nxt();

        // Reset while the error slave is draining W
        m_if.aw_valid[0] = 1'b1; m_if.aw_addr[0] = 8'hF0; m_if.aw_len[0] = 8'd1; m_if.aw_id[0] = 2'd2;
        #1;
        chk("rstw_aw_ready", m_if.aw_ready[0], 1);
        nxt();
        m_if.aw_valid[0] = 1'b0;
        m_if.w_valid[0] = 1'b1; m_if.w_last[0] = 1'b0;
        #1;
        chk("rstw_w_ready", m_if.w_ready[0], 1);
        nxt();
        m_if.w_last[0] = 1'b1; m_if.b_ready[0] = 1'b1;
        rstn = 1'b0;
        #1;
        chk("rstw_w_dropped", m_if.w_ready[0], 0);
        chk("rstw_no_b", m_if.b_valid[0], 0);
        nxt();
        nxt();
        rstn = 1'b1;
        m_if.w_valid[0] = 1'b0; m_if.w_last[0] = 1'b0;
        nxt();
        chk("rstw_no_b_after", m_if.b_valid[0], 0);
        m_if.aw_valid[0] = 1'b1; m_if.aw_addr[0] = 8'hF0;
        #1;
        chk("rstw_es_idle", m_if.aw_ready[0], 1);
        chk("rstw_w_unlocked", m_if.w_ready[0], 0);
        m_if.aw_addr[0] = 8'h10; m_if.aw_len[0] = 8'd0; m_if.aw_id[0] = 2'd1;
        #1;
        chk("rstw_next_aw_ready", m_if.aw_ready[0], 1);
        chk("rstw_next_s_aw", s_if.aw_valid, 8'h02);
        nxt();
        m_if.aw_valid[0] = 1'b0;
        m_if.w_valid[0] = 1'b1; m_if.w_last[0] = 1'b1;
        #1;
        chk("rstw_next_w", s_if.w_valid, 8'h02);
        nxt();
        m_if.w_valid[0] = 1'b0; m_if.w_last[0] = 1'b0;
        s_if.b_valid[1] = 1'b1; s_if.b_id[1] = 2'd1; s_if.b_resp[1] = RESP_OKAY;
        #1;
        chk("rstw_next_b_valid", m_if.b_valid[0], 1);
        chk("rstw_next_b_id", m_if.b_id[0], 1);
        chk("rstw_next_b_resp", m_if.b_resp[0], 0);
        nxt();
        s_if.b_valid[1] = 1'b0; m_if.b_ready[0] = 1'b0;
        nxt();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
